// File: rtl/uart_tx_word_sched_if.sv
// Bundle between the word scheduler, its source FIFOs and the UART word serializer.
// master = scheduler side, slave = FIFO/serializer side.
interface uart_tx_word_sched_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 3
);
  logic [N_CH-1:0]    i_ch_en;
  logic [N_CH-1:0]    i_ch_empty;
  logic [32*N_CH-1:0] i_ch_data;
  logic [N_CH-1:0]    o_ch_rd_en;
  logic               i_word_req;
  logic [31:0]        o_word_data;
  logic               o_word_valid;
  logic               o_sent_pulse;
  logic [CH_W-1:0]    o_sent_ch;
  logic               o_underrun;
  logic [15:0]        o_underrun_cnt;

  modport master (
    input  i_ch_en, i_ch_empty, i_ch_data, i_word_req,
    output o_ch_rd_en, o_word_data, o_word_valid, o_sent_pulse,
           o_sent_ch, o_underrun, o_underrun_cnt
  );

  modport slave (
    output i_ch_en, i_ch_empty, i_ch_data, i_word_req,
    input  o_ch_rd_en, o_word_data, o_word_valid, o_sent_pulse,
           o_sent_ch, o_underrun, o_underrun_cnt
  );
endinterface

// File: rtl/uart_tx_word_sched.sv
// Round-robin prefetcher feeding one 32-bit UART word serializer from N_CH FIFOs.
// Presents IDLE_WORD whenever no fetched word is held.
module uart_tx_word_sched #(
  parameter int          N_CH      = 4,
  parameter int          CH_W      = 3,
  parameter logic [31:0] IDLE_WORD = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  uart_tx_word_sched_if.master   bus
);

  typedef enum logic [2:0] {IDLE, ARB, RD, CAP, FULL} state_t;

  state_t            state, state_nxt;
  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   elig_rot;
  logic [N_CH-1:0]   rd_en;
  logic [CH_W-1:0]   grant, last_grant, arb_ch;
  logic              arb_found;
  int unsigned       idx;
  logic [31:0]       hold, cap_word;
  logic              hold_valid, req_d;
  logic              sent_pulse, underrun;
  logic [CH_W-1:0]   sent_ch;
  logic [15:0]       underrun_cnt;

  assign elig = bus.i_ch_en & ~bus.i_ch_empty;

  // First eligible channel after last_grant, wrapping modulo N_CH.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    idx       = 0;
    elig_rot  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx      = (32'(last_grant) + 32'd1 + i) % N_CH;
      elig_rot = elig >> idx;
      if (!arb_found && elig_rot[0]) begin
        arb_found = 1'b1;
        arb_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    cap_word = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant == CH_W'(k)) cap_word = bus.i_ch_data[32*k +: 32];
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = '0;
    case (state)
      IDLE: if (!hold_valid && (|elig)) state_nxt = ARB;
      ARB:  state_nxt = arb_found ? RD : IDLE;
      RD: begin
        rd_en     = N_CH'(1) << grant;
        state_nxt = CAP;
      end
      CAP:  state_nxt = FULL;
      FULL: if (req_d) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // hold doubles as the registered output mux: it reads IDLE_WORD whenever hold_valid is 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant        <= '0;
      last_grant   <= CH_W'(N_CH - 1);
      hold         <= IDLE_WORD;
      hold_valid   <= 1'b0;
      req_d        <= 1'b0;
      sent_pulse   <= 1'b0;
      sent_ch      <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      req_d      <= bus.i_word_req;
      sent_pulse <= 1'b0;
      underrun   <= 1'b0;
      if (state == ARB && arb_found) grant <= arb_ch;
      if (state == CAP) begin
        hold       <= cap_word;
        hold_valid <= 1'b1;
        last_grant <= grant;
      end
      if (req_d) begin
        if (hold_valid) begin
          hold       <= IDLE_WORD;
          hold_valid <= 1'b0;
          sent_pulse <= 1'b1;
          sent_ch    <= last_grant;
        end else begin
          underrun <= 1'b1;
          if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.o_ch_rd_en     = rd_en;
  assign bus.o_word_data    = hold;
  assign bus.o_word_valid   = hold_valid;
  assign bus.o_sent_pulse   = sent_pulse;
  assign bus.o_sent_ch      = sent_ch;
  assign bus.o_underrun     = underrun;
  assign bus.o_underrun_cnt = underrun_cnt;

endmodule

// File: tb/tb_uart_tx_word_sched.sv
// Self-checking bench: FIFO models, a latency-timeline reference of the scheduler,
// directed scenarios with literal expectations, then a randomized phase.
module tb_uart_tx_word_sched;
  localparam int          N    = 4;
  localparam int          CW   = 3;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_word_sched_if #(.N_CH(N), .CH_W(CW)) bus ();

  uart_tx_word_sched #(.N_CH(N), .CH_W(CW), .IDLE_WORD(IDLE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // stimulus for the current cycle
  logic       s_req = 1'b0;
  logic       s_rst = 1'b1;
  logic [3:0] s_en  = 4'b1111;

  // FIFO contents seen by the DUT, and the model's own copy
  logic [31:0] fq[N][$];
  logic [31:0] mq[N][$];
  logic [31:0] fdata[N];

  // reference model: expected outputs for the current cycle
  logic        m_valid, m_sent, m_under, m_req_d;
  logic [31:0] m_word, m_pend;
  logic [2:0]  m_sch;
  logic [15:0] m_cnt;
  logic [3:0]  m_rd;
  int          m_last, m_grant, fs, idle_from;

  // observation logs for literal checks
  logic [2:0]  slog_ch[$];
  logic [31:0] slog_w[$];
  logic [31:0] prev_word = IDLE;
  logic        prev_valid = 1'b0;
  int          rd2_cyc, vrise_cyc, under_seen;
  logic [3:0]  first_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_word = IDLE; m_sch = '0; m_sent = 1'b0; m_under = 1'b0;
    m_cnt = '0; m_rd = '0; m_last = N - 1; m_req_d = 1'b0; fs = -1; idle_from = 0;
    m_grant = 0; m_pend = '0;
  endtask

  // Spec timeline: eligible in IDLE at t -> pick at t+1, read at t+2, held from t+4.
  task automatic model_step();
    logic [3:0]  e;
    logic        n_valid, n_sent, n_under, found;
    logic [31:0] n_word;
    logic [2:0]  n_sch;
    logic [15:0] n_cnt;
    logic [3:0]  n_rd;
    int          n_last, c;
    e = bus.i_ch_en & ~bus.i_ch_empty;
    if (s_rst) begin
      model_reset();
      return;
    end
    n_valid = m_valid; n_word = m_word; n_sch = m_sch; n_cnt = m_cnt; n_last = m_last;
    n_sent = 1'b0; n_under = 1'b0; n_rd = '0;
    if (m_req_d) begin
      if (m_valid) begin
        n_valid = 1'b0; n_word = IDLE; n_sent = 1'b1; n_sch = 3'(m_last);
        idle_from = cyc + 1;
      end else begin
        n_under = 1'b1;
        if (m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
      end
    end
    if (fs >= 0) begin
      if (cyc == fs + 1) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          c = (m_last + 1 + i) % N;
          if (!found && e[c[1:0]]) begin
            found = 1'b1;
            m_grant = c;
          end
        end
        if (found) n_rd = 4'(1 << m_grant);
        else begin
          fs = -1;
          idle_from = cyc + 1;
        end
      end else if (cyc == fs + 2) begin
        m_pend = (mq[m_grant].size() > 0) ? mq[m_grant].pop_front() : 32'hDEAD_BEEF;
      end else if (cyc == fs + 3) begin
        n_valid = 1'b1; n_word = m_pend; n_last = m_grant; fs = -1;
      end
    end else if (!m_valid && cyc >= idle_from && e != 4'b0000) begin
      fs = cyc;
    end
    m_valid = n_valid; m_word = n_word; m_sch = n_sch; m_cnt = n_cnt; m_last = n_last;
    m_sent = n_sent; m_under = n_under; m_rd = n_rd; m_req_d = s_req;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check("rd_en",      64'(bus.o_ch_rd_en),     64'(m_rd));
    check("word_data",  64'(bus.o_word_data),    64'(m_word));
    check("word_valid", 64'(bus.o_word_valid),   64'(m_valid));
    check("sent_pulse", 64'(bus.o_sent_pulse),   64'(m_sent));
    check("sent_ch",    64'(bus.o_sent_ch),      64'(m_sch));
    check("underrun",   64'(bus.o_underrun),     64'(m_under));
    check("under_cnt",  64'(bus.o_underrun_cnt), 64'(m_cnt));
    if (bus.o_sent_pulse) begin
      slog_ch.push_back(bus.o_sent_ch);
      slog_w.push_back(prev_word);
    end
    if (bus.o_ch_rd_en[2] && rd2_cyc < 0) rd2_cyc = cyc;
    if (bus.o_word_valid && !prev_valid && vrise_cyc < 0) vrise_cyc = cyc;
    if (bus.o_ch_rd_en != 4'b0000 && first_rd == 4'b0000) first_rd = bus.o_ch_rd_en;
    if (bus.o_underrun) under_seen++;
    prev_word  = bus.o_word_data;
    prev_valid = bus.o_word_valid;
    for (int k = 0; k < N; k++) begin
      if (bus.o_ch_rd_en[k]) fdata[k] = (fq[k].size() > 0) ? fq[k].pop_front() : 32'hDEAD_BEEF;
    end
    rst            = s_rst;
    bus.i_word_req = s_req;
    bus.i_ch_en    = s_en;
    for (int k = 0; k < N; k++) begin
      bus.i_ch_empty[k]         = (fq[k].size() == 0);
      bus.i_ch_data[32*k +: 32] = fdata[k];
    end
    model_step();
    s_req = 1'b0;
  endtask

  task automatic load(input int k, input logic [31:0] w);
    fq[k].push_back(w);
    mq[k].push_back(w);
  endtask

  task automatic clear_obs();
    slog_ch.delete();
    slog_w.delete();
    rd2_cyc = -1; vrise_cyc = -1; under_seen = 0; first_rd = '0;
  endtask

  task automatic check_log(input int j, input logic [2:0] ch, input logic [31:0] w);
    if (j < slog_ch.size()) begin
      check("order_ch", 64'(slog_ch[j]), 64'(ch));
      check("order_w",  64'(slog_w[j]),  64'(w));
    end else begin
      check("order_missing", 64'(slog_ch.size()), 64'(j + 1));
    end
  endtask

  initial begin
    int t_e;
    logic prev_req;
    for (int k = 0; k < N; k++) fdata[k] = '0;
    bus.i_ch_en = '0; bus.i_ch_empty = '1; bus.i_ch_data = '0; bus.i_word_req = 1'b0;
    model_reset();
    clear_obs();
    #1 rst = 1'b1;
    repeat (3) tick();
    s_rst = 1'b0;
    tick();

    // all FIFOs empty: every request is an underrun
    clear_obs();
    for (int r = 0; r < 3; r++) begin
      repeat (511) tick();
      s_req = 1'b1;
      tick();
    end
    repeat (4) tick();
    check("idle_cnt",   64'(bus.o_underrun_cnt), 64'd3);
    check("idle_pulses", 64'(under_seen),        64'd3);
    check("idle_word",  64'(bus.o_word_data),    64'hFFFF_FFFF);

    // round robin over four loaded channels
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 2; i++) load(k, 32'hA000_0000 + 32'(10 * k + i));
    repeat (10) tick();
    clear_obs();
    for (int j = 0; j < 8; j++) begin
      s_req = 1'b1;
      tick();
      repeat (11) tick();
    end
    check("rr_count", 64'(slog_ch.size()), 64'd8);
    for (int j = 0; j < 8; j++) check_log(j, 3'(j % 4), 32'hA000_0000 + 32'(10 * (j % 4) + j / 4));
    check("rr_no_underrun", 64'(bus.o_underrun_cnt), 64'd3);

    // fetch latency with only ch2 populated
    clear_obs();
    load(2, 32'h1234_5678);
    tick();
    t_e = cyc;
    repeat (8) tick();
    check("lat_rd",    64'(rd2_cyc - t_e),       64'd2);
    check("lat_valid", 64'(vrise_cyc - rd2_cyc), 64'd2);
    s_req = 1'b1;
    tick();
    tick();
    check("strobe_t1", 64'(bus.o_word_data), 64'h1234_5678);
    tick();
    check("strobe_t2", 64'(bus.o_word_data), 64'hFFFF_FFFF);
    repeat (6) tick();

    // request landing on the RD cycle
    clear_obs();
    load(0, 32'hCAFE_0001);
    tick();
    tick();
    s_req = 1'b1;
    tick();
    check("rdcol_rd", 64'(bus.o_ch_rd_en), 64'b0001);
    repeat (4) tick();
    check("rdcol_cnt",   64'(bus.o_underrun_cnt), 64'd4);
    check("rdcol_valid", 64'(bus.o_word_valid),   64'd1);
    check("rdcol_word",  64'(bus.o_word_data),    64'hCAFE_0001);
    s_req = 1'b1;
    tick();
    repeat (3) tick();
    check_log(0, 3'd0, 32'hCAFE_0001);

    // only ch1 and ch3 enabled
    s_en = 4'b1010;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 3; i++) load(k, 32'hB000_0000 + 32'(16 * k + i));
    repeat (10) tick();
    clear_obs();
    for (int j = 0; j < 4; j++) begin
      s_req = 1'b1;
      tick();
      repeat (11) tick();
    end
    check_log(0, 3'd1, 32'hB000_0010);
    check_log(1, 3'd3, 32'hB000_0030);
    check_log(2, 3'd1, 32'hB000_0011);
    check_log(3, 3'd3, 32'hB000_0031);

    // flush under reset
    s_en = 4'b0000;
    s_rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      fq[k].delete();
      mq[k].delete();
    end
    s_rst = 1'b0;
    repeat (3) tick();

    // reset during CAP, next grant returns to ch0
    s_en = 4'b1111;
    load(1, 32'hC1C1_C1C1);
    tick();
    tick();
    tick();
    check("rst_rd_ch1", 64'(bus.o_ch_rd_en), 64'b0010);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    tick();
    check("rst_valid", 64'(bus.o_word_valid),   64'd0);
    check("rst_word",  64'(bus.o_word_data),    64'hFFFF_FFFF);
    check("rst_cnt",   64'(bus.o_underrun_cnt), 64'd0);
    clear_obs();
    load(0, 32'hD000_0000);
    load(2, 32'hD000_0002);
    repeat (8) tick();
    check("rst_first_grant", 64'(first_rd), 64'b0001);

    // randomized traffic against the model
    prev_req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int k;
      if ($urandom_range(0, 49) == 0) s_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        k = int'($urandom_range(0, N - 1));
        if (fq[k].size() < 6) load(k, $urandom);
      end
      if (!prev_req && $urandom_range(0, 9) == 0) s_req = 1'b1;
      prev_req = s_req;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_word_sched.md
# uart_tx_word_sched

Round-robin scheduler sharing one 32-bit UART word serializer among N_CH source FIFOs. Prefetches one word from an eligible channel into a holding register and presents it on the serializer data input. When the serializer strobes its word-read request, the held word is consumed and the next fetch starts. If no word is ready, the block presents IDLE_WORD, so the serial line stays idle-high.

## Interface
Parameters:
- N_CH, 4: number of source FIFOs; 2..8.
- CH_W, 3: channel index width; must be ≥ clog2(N_CH).
- IDLE_WORD, 32'hFFFF_FFFF: word presented when no data is held.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_ch_en  in  N_CH  per-channel enable mask; level.
- i_ch_empty  in  N_CH  FIFO empty flags.
- i_ch_data  in  32*N_CH  FIFO read data; channel k is bits [32k+31:32k]; valid one cycle after its rd_en.
- o_ch_rd_en  out  N_CH  one-hot, one-cycle FIFO read pulse.
- i_word_req  in  1  serializer word-read strobe, one cycle wide.
- o_word_data  out  32  word to the serializer input.
- o_word_valid  out  1  holding register contains an unconsumed word.
- o_sent_pulse  out  1  one-cycle pulse when a held word is consumed.
- o_sent_ch  out  CH_W  channel of the last consumed word.
- o_underrun  out  1  one-cycle pulse when a request is served with IDLE_WORD.
- o_underrun_cnt  out  16  saturating underrun count.

## Operation
- The FSM has five states: IDLE, ARB, RD, CAP, FULL.
- IDLE:
  - Go to ARB when hold_valid=0 and any channel has i_ch_en=1 and i_ch_empty=0.
- ARB, one cycle:
  - Search for an eligible channel starting at last_grant+1, wrapping modulo N_CH.
  - If one is found, register it in grant and go to RD.
  - If none is found, return to IDLE.
- RD, one cycle:
  - o_ch_rd_en[grant]=1. Go to CAP.
- CAP, one cycle:
  - Load hold ← i_ch_data[grant], set hold_valid=1, set last_grant ← grant. Go to FULL.
- FULL:
  - Remain here until the consume event clears hold_valid, then go to IDLE.
- Consume rule:
  - req_d is i_word_req delayed by one cycle.
  - The serializer loads o_word_data during the cycle after its strobe, so the word presented while req_d=1 is the word consumed.
  - If req_d=1 and hold_valid=1: clear hold_valid, pulse o_sent_pulse, set o_sent_ch ← last_grant.
  - If req_d=1 and hold_valid=0: pulse o_underrun and increment o_underrun_cnt, saturating at 16'hFFFF.
  - CAP sets hold_valid only while it is 0, and the consume rule clears it only while it is 1, so the two never collide.
- Output mux: o_word_data = hold_valid ? hold : IDLE_WORD.
  - It is registered, so its value is stable for the whole req_d cycle.
- Disabling a channel via i_ch_en does not abort a fetch already in RD or CAP.
  - The fetched word is held and delivered normally.
- i_word_req arriving in any state is handled only by the consume rule; it never changes FSM state directly.

## Timing
- Reset values:
  - o_ch_rd_en=0, o_word_data=IDLE_WORD, o_word_valid=0.
  - o_sent_pulse=0, o_sent_ch=0, o_underrun=0, o_underrun_cnt=0.
  - State IDLE, last_grant=N_CH-1, so the first grant goes to channel 0.
- Fetch latency: a non-empty channel seen in IDLE at cycle t gives ARB at t+1, rd_en at t+2, capture at the end of t+3, and o_word_valid=1 from t+4.
- Request strobe at cycle T:
  - The word shown in T+1 is the one consumed.
  - o_sent_pulse or o_underrun fires in T+2.
  - A new ARB can start in T+3.
- The worst-case refill (5 cycles) is far shorter than the serializer word period, so back-to-back traffic never underruns once the first word is held.
- Asserting i_rst mid-fetch drops any in-flight word. The FIFO read already issued is lost by design.

## Test plan
- Reset, then all FIFOs empty and i_word_req pulsed every 512 cycles:
  - o_word_data=32'hFFFFFFFF throughout.
  - o_underrun pulses once per request; o_underrun_cnt=3 after 3 requests.
- ch0..ch3 each preloaded with 2 words (values 0xA0000000+10k+i), all enabled, 8 requests:
  - Consume order is ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3.
  - o_sent_ch matches each word; zero underruns.
- Only ch2 non-empty, holding 0x12345678:
  - rd_en[2] fires exactly 2 cycles after ch2 is eligible in IDLE.
  - o_word_valid rises 2 cycles after rd_en.
  - On a strobe at T, o_word_data=0x12345678 during T+1 and IDLE_WORD from T+2.
- i_word_req strobed in the same cycle as RD:
  - That request counts as an underrun.
  - The fetched word is held and delivered on the next strobe.
- i_ch_en=4'b1010 with all channels non-empty:
  - Only ch1 and ch3 are granted, alternating.
- i_rst asserted in CAP:
  - All outputs return to their reset values on the next edge.
  - The following grant goes to ch0.
